// File: rtl/bkg_addr_gen.sv
// Background RAM address generator: 8x/4x scaled, vertically tiled, frame-synchronous scroll.
// Define BKG_SCROLL_EN to build the scroll accumulator; otherwise scroll_y is tied to 0.
module bkg_addr_gen #(
   parameter int IMG_W  = 80,
   parameter int IMG_H  = 96,
   parameter int XSHIFT = 3,
   parameter int YSHIFT = 2
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic [9:0]  DrawX,
   input  logic [9:0]  DrawY,
   input  logic        blank,
   input  logic        vs,
   input  logic        scroll_req,
   input  logic [7:0]  scroll_amt,
   output logic [12:0] read_address,
   output logic        bkg_valid,
   output logic [8:0]  scroll_y
);

   localparam logic [9:0]  LINES   = 10'(IMG_H << YSHIFT);
   localparam logic [12:0] IMG_W13 = 13'(IMG_W);

   logic [9:0]  ym;
   logic [9:0]  line;
   logic [9:0]  row;
   logic [12:0] addr_d;
   logic        blank_q;

   always_comb begin
      ym     = '0;
      line   = '0;
      row    = '0;
      addr_d = '0;
      ym     = (DrawY >= LINES) ? DrawY - LINES : DrawY;
      line   = (ym >= {1'b0, scroll_y}) ? ym - {1'b0, scroll_y}
                                        : ym + LINES - {1'b0, scroll_y};
      row    = line >> YSHIFT;
      addr_d = {3'b000, row} * IMG_W13 + {3'b000, DrawX >> XSHIFT};
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         read_address <= '0;
         blank_q      <= 1'b0;
         bkg_valid    <= 1'b0;
      end else begin
         read_address <= addr_d;
         blank_q      <= blank;
         bkg_valid    <= blank_q;
      end
   end

`ifdef BKG_SCROLL_EN
   logic        vs_q;
   logic [8:0]  pending;
   logic [8:0]  scroll_r;
   logic        frame_start;
   logic [9:0]  pend_sum;
   logic [8:0]  pend_next;
   logic [10:0] commit_sum;
   logic [10:0] commit_red;
   logic [8:0]  commit_next;

   // Sum stays below 3*LINES, so at most two subtracts wrap it into range.
   always_comb begin
      frame_start = ~vs_q & vs;
      pend_sum    = {1'b0, pending} + {2'b00, scroll_amt};
      pend_next   = (pend_sum >= LINES) ? 9'(pend_sum - LINES) : pend_sum[8:0];
      commit_sum  = {2'b00, scroll_r} + {2'b00, pending}
                  + (scroll_req ? {3'b000, scroll_amt} : 11'd0);
      commit_red  = (commit_sum >= {1'b0, LINES}) ? commit_sum - {1'b0, LINES} : commit_sum;
      commit_red  = (commit_red >= {1'b0, LINES}) ? commit_red - {1'b0, LINES} : commit_red;
      commit_next = commit_red[8:0];
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         vs_q     <= 1'b1;
         pending  <= '0;
         scroll_r <= '0;
      end else begin
         vs_q <= vs;
         if (frame_start) begin
            scroll_r <= commit_next;
            pending  <= '0;
         end else if (scroll_req) begin
            pending <= pend_next;
         end
      end
   end

   assign scroll_y = scroll_r;
`else
   logic unused_scroll;
   assign unused_scroll = &{1'b0, vs, scroll_req, scroll_amt};
   assign scroll_y      = '0;
`endif

endmodule
